// File: rtl/mux_stream_arb_pkg.sv
// Shared stream-block definitions: mode encoding and index helpers used by
// the stream multiplexer and its round-robin arbiter.
package mux_stream_arb_pkg;

    localparam logic MODE_SELECT      = 1'b0;
    localparam logic MODE_ROUND_ROBIN = 1'b1;

    typedef enum logic {
        STREAM_MODE_SELECT      = 1'b0,
        STREAM_MODE_ROUND_ROBIN = 1'b1
    } stream_mode_e;

    // Channel index reached by stepping `offset` places past `base`, modulo n.
    function automatic int wrap_idx(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/mux_stream_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after `last`,
// wrapping modulo N. The pointer register belongs to the caller.
module rr_arbiter
    import mux_stream_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]         request,
    input  logic [$clog2(N)-1:0] last,
    input  logic                 enable,
    output logic [N-1:0]         grant_onehot,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_any
);

    localparam int SEL_W = $clog2(N);

    always_comb begin
        int idx;
        idx          = 0;
        grant_onehot = '0;
        grant_idx    = '0;
        grant_any    = 1'b0;
        if (enable) begin
            // Offset N revisits `last` itself, so a lone requester can be regranted.
            for (int k = 1; k <= N; k++) begin
                idx = wrap_idx(int'(last), k, N);
                if (!grant_any && request[idx]) begin
                    grant_any         = 1'b1;
                    grant_onehot[idx] = 1'b1;
                    grant_idx         = SEL_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/mux_stream_arb.sv
// Registered N-channel valid/ready stream multiplexer with software-select or
// round-robin channel choice feeding one shared consumer.
module mux_stream_arb
    import mux_stream_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         in_valid,
    output logic [CHANNELS-1:0]         in_ready,
    input  logic                        mode,
    input  logic [$clog2(CHANNELS)-1:0] sel,
    output logic [WIDTH-1:0]            out_data,
    output logic [$clog2(CHANNELS)-1:0] out_chan,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int SEL_W = $clog2(CHANNELS);

    logic                load;
    logic                arb_en;
    logic                sel_hit;
    logic [CHANNELS-1:0] sel_onehot;
    logic [CHANNELS-1:0] rr_onehot;
    logic [SEL_W-1:0]    rr_idx;
    logic                rr_any;
    logic                grant_any;
    logic [SEL_W-1:0]    grant_idx;
    logic [CHANNELS-1:0] grant_onehot;
    logic [WIDTH-1:0]    grant_data;
    logic [SEL_W-1:0]    last;

    assign load   = !out_valid || out_ready;
    assign arb_en = rst_n && load && (mode == MODE_ROUND_ROBIN);

    rr_arbiter #(
        .N (CHANNELS)
    ) u_rr_arbiter (
        .request      (in_valid),
        .last         (last),
        .enable       (arb_en),
        .grant_onehot (rr_onehot),
        .grant_idx    (rr_idx),
        .grant_any    (rr_any)
    );

    // Comparing against every legal index means an out-of-range sel never matches.
    always_comb begin
        sel_hit    = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((int'(sel) == i) && in_valid[i]) begin
                sel_hit       = 1'b1;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_any    = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        if (rst_n && load) begin
            if (mode == MODE_SELECT) begin
                grant_any    = sel_hit;
                grant_idx    = sel;
                grant_onehot = sel_onehot;
            end else begin
                grant_any    = rr_any;
                grant_idx    = rr_idx;
                grant_onehot = rr_onehot;
            end
        end
    end

    assign in_ready = grant_onehot;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_onehot[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage; `last` resets to the top channel so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= SEL_W'(CHANNELS - 1);
        end else if (load) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant_idx;
                last      <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_stream_arb.sv
// Directed bench for mux_stream_arb: a vector table on an 8-channel instance
// plus a hand sequence on a 5-channel instance for out-of-range select and wrap.
module tb_mux_stream_arb;

    logic        clk;

    logic        rst_n;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic [2:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic        rst_n5;
    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        mode5;
    logic [2:0]  sel5;
    logic [7:0]  out_data5;
    logic [2:0]  out_chan5;
    logic        out_valid5;
    logic        out_ready5;

    int checks;
    int failures;

    mux_stream_arb #(.WIDTH(8), .CHANNELS(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_stream_arb #(.WIDTH(8), .CHANNELS(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n5),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_chan  (out_chan5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       mode;
        logic [2:0] sel;
        logic [7:0] valid;
        logic       ordy;
        logic [7:0] e_rdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_oc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic m, input logic [2:0] s,
                                input logic [7:0] v, input logic o, input logic [7:0] erdy,
                                input logic eov, input logic [7:0] eod, input logic [2:0] eoc);
        vec_t t;
        t.rst_n = r;   t.mode = m;    t.sel = s;    t.valid = v; t.ordy = o;
        t.e_rdy = erdy; t.e_ov = eov; t.e_od = eod; t.e_oc = eoc;
        return t;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic step5(input int idx, input logic r, input logic m, input logic [2:0] s,
                         input logic [4:0] v, input logic o, input logic [4:0] erdy,
                         input logic eov, input logic [7:0] eod, input logic [2:0] eoc);
        @(negedge clk);
        rst_n5 = r; mode5 = m; sel5 = s; in_valid5 = v; out_ready5 = o;
        #1;
        check("c5_in_ready", idx, 32'(in_ready5), 32'(erdy));
        @(posedge clk);
        #1;
        check("c5_out_valid", idx, 32'(out_valid5), 32'(eov));
        check("c5_out_data", idx, 32'(out_data5), 32'(eod));
        check("c5_out_chan", idx, 32'(out_chan5), 32'(eoc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic prev_ov;
        checks   = 0;
        failures = 0;
        prev_ov  = 1'b0;

        rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
        rst_n5 = 1'b0; mode5 = 1'b0; sel5 = '0; in_valid5 = '0; out_ready5 = 1'b1;
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'hA0 + 8'(i);

        //                rst mode sel   valid  ordy  e_rdy  ov  od     oc
        // reset with every channel requesting
        tbl.push_back(mk(0, 0, 3'd0, 8'hFF, 1, 8'h00, 0, 8'h00, 3'd0));
        tbl.push_back(mk(0, 0, 3'd0, 8'hFF, 1, 8'h00, 0, 8'h00, 3'd0));
        tbl.push_back(mk(0, 0, 3'd0, 8'hFF, 1, 8'h00, 0, 8'h00, 3'd0));
        // SELECT channel 5, then 2
        tbl.push_back(mk(1, 0, 3'd5, 8'hFF, 1, 8'h20, 1, 8'h15, 3'd5));
        tbl.push_back(mk(1, 0, 3'd5, 8'hFF, 1, 8'h20, 1, 8'h15, 3'd5));
        tbl.push_back(mk(1, 0, 3'd5, 8'hFF, 1, 8'h20, 1, 8'h15, 3'd5));
        tbl.push_back(mk(1, 0, 3'd2, 8'hFF, 1, 8'h04, 1, 8'h12, 3'd2));
        // reset, then round-robin over channels 0,3,7
        tbl.push_back(mk(0, 1, 3'd0, 8'h89, 1, 8'h00, 0, 8'h00, 3'd0));
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 1, 8'h01, 1, 8'h10, 3'd0));
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 1, 8'h08, 1, 8'h13, 3'd3));
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 1, 8'h80, 1, 8'h17, 3'd7));
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 1, 8'h01, 1, 8'h10, 3'd0));
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 1, 8'h08, 1, 8'h13, 3'd3));
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 1, 8'h80, 1, 8'h17, 3'd7));
        // backpressure: one word, 5 stalled cycles, release loads channel 3
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 1, 8'h01, 1, 8'h10, 3'd0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 1, 3'd0, 8'h89, 0, 8'h00, 1, 8'h10, 3'd0));
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 1, 8'h08, 1, 8'h13, 3'd3));
        // no requester: valid drops, data/chan hold
        tbl.push_back(mk(1, 1, 3'd0, 8'h00, 1, 8'h00, 0, 8'h13, 3'd3));
        // select 6 then RR continues from 6
        tbl.push_back(mk(1, 0, 3'd6, 8'h40, 1, 8'h40, 1, 8'h16, 3'd6));
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 1, 8'h80, 1, 8'h17, 3'd7));
        // reset while stalled, then first RR grant is channel 0
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 0, 8'h00, 1, 8'h17, 3'd7));
        tbl.push_back(mk(0, 1, 3'd0, 8'h89, 0, 8'h00, 0, 8'h00, 3'd0));
        tbl.push_back(mk(1, 1, 3'd0, 8'h89, 1, 8'h01, 1, 8'h10, 3'd0));
        // select a non-requesting channel, then RR skips idle channel 1
        tbl.push_back(mk(1, 0, 3'd1, 8'hFD, 1, 8'h00, 0, 8'h10, 3'd0));
        tbl.push_back(mk(1, 1, 3'd0, 8'hFD, 1, 8'h04, 1, 8'h12, 3'd2));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; mode = tbl[i].mode; sel = tbl[i].sel;
            in_valid = tbl[i].valid; out_ready = tbl[i].ordy;
            #1;
            check("in_ready", i, 32'(in_ready), 32'(tbl[i].e_rdy));
            if (i > 0) check("no_comb_out_valid", i, 32'(out_valid), 32'(prev_ov));
            @(posedge clk);
            #1;
            check("out_valid", i, 32'(out_valid), 32'(tbl[i].e_ov));
            check("out_data", i, 32'(out_data), 32'(tbl[i].e_od));
            check("out_chan", i, 32'(out_chan), 32'(tbl[i].e_oc));
            prev_ov = tbl[i].e_ov;
        end

        // 5-channel instance: out-of-range select and RR pointer wrap
        step5(0, 0, 0, 3'd0, 5'h1F, 1, 5'h00, 0, 8'h00, 3'd0);
        step5(1, 1, 0, 3'd3, 5'h1F, 1, 5'h08, 1, 8'hA3, 3'd3);
        step5(2, 1, 0, 3'd6, 5'h1F, 1, 5'h00, 0, 8'hA3, 3'd3);
        step5(3, 1, 0, 3'd5, 5'h1F, 1, 5'h00, 0, 8'hA3, 3'd3);
        step5(4, 1, 1, 3'd0, 5'h10, 1, 5'h10, 1, 8'hA4, 3'd4);
        step5(5, 1, 1, 3'd0, 5'h01, 1, 5'h01, 1, 8'hA0, 3'd0);
        step5(6, 1, 1, 3'd0, 5'h10, 1, 5'h10, 1, 8'hA4, 3'd4);
        step5(7, 1, 1, 3'd0, 5'h01, 1, 5'h01, 1, 8'hA0, 3'd0);
        step5(8, 1, 1, 3'd0, 5'h1F, 0, 5'h00, 1, 8'hA0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
